// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory master port between the
// instruction-fetch port and the data-access port. One transaction is in
// flight at a time; the winner's request is registered, driven onto the
// shared port, and its read data returned with a one-cycle data_ok pulse.
//
// Handshake: a requester's *_req is offered each cycle; the request is taken
// in the cycle where the matching *_addr_ok is high (only ever in IDLE, never
// both ports at once). On the shared side, m_req holds with stable fields
// until the slave answers m_addr_ok; m_data_ok then marks m_rdata valid,
// possibly in the same cycle as m_addr_ok.
module mem_port_arbiter #(
    parameter bit FAIR = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant;
    logic        pick_data;
    logic        capture;
    logic        grant_is_data;
    logic        last_data;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    // Arbitration: decide which port wins if a grant happens this cycle.
    always_comb begin
        pick_data = data_req;
        if (FAIR) begin
            // With both requesting, the port that did not win last time goes.
            pick_data = data_req && (!inst_req || !last_data);
        end
        grant = (state == S_IDLE) && (inst_req || data_req) && !reset;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and FSM-driven outputs.
    always_comb begin
        state_next   = state;
        m_req        = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        capture      = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                m_req = 1'b1;
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        capture    = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (m_data_ok) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                inst_data_ok = !grant_is_data;
                data_data_ok = grant_is_data;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request fields, grant history and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_is_data <= 1'b0;
            last_data     <= 1'b0;
            r_wr          <= 1'b0;
            r_size        <= 2'd0;
            r_wstrb       <= 4'd0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_rdata       <= 32'd0;
        end else begin
            if (grant) begin
                grant_is_data <= pick_data;
                last_data     <= pick_data;
                if (pick_data) begin
                    r_wr    <= data_wr;
                    r_size  <= data_size;
                    r_wstrb <= data_wstrb;
                    r_addr  <= data_addr;
                    r_wdata <= data_wdata;
                end else begin
                    // Fetches are always word reads.
                    r_wr    <= 1'b0;
                    r_size  <= 2'd2;
                    r_wstrb <= 4'd0;
                    r_addr  <= inst_addr;
                    r_wdata <= 32'd0;
                end
            end
            if (capture) begin
                r_rdata <= m_rdata;
            end
        end
    end

    assign inst_addr_ok = grant && !pick_data;
    assign data_addr_ok = grant && pick_data;
    assign inst_rdata   = r_rdata;
    assign data_rdata   = r_rdata;
    assign m_wr         = r_wr;
    assign m_size       = r_size;
    assign m_wstrb      = r_wstrb;
    assign m_addr       = r_addr;
    assign m_wdata      = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a fixed-priority instance (u0) is fully
// scoreboarded; a round-robin instance (u1) shares all inputs and is used for
// the fairness sequence. Both see the same slave timing so they stay in step.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    logic        inst_addr_ok0, inst_data_ok0, data_addr_ok0, data_data_ok0;
    logic [31:0] inst_rdata0, data_rdata0;
    logic        m_req0, m_wr0;
    logic [1:0]  m_size0;
    logic [3:0]  m_wstrb0;
    logic [31:0] m_addr0, m_wdata0;

    logic        inst_addr_ok1, inst_data_ok1, data_addr_ok1, data_data_ok1;
    logic [31:0] inst_rdata1, data_rdata1;
    logic        m_req1, m_wr1;
    logic [1:0]  m_size1;
    logic [3:0]  m_wstrb1;
    logic [31:0] m_addr1, m_wdata1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] exp_q[$];   // {check_rdata, is_data, rdata}
    logic [1:0]  g1;         // u1 grant seen by the last transaction {inst, data}

    // Clock and DUTs
    always #5 clk = ~clk;

    mem_port_arbiter #(.FAIR(1'b0)) u0 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok0),
        .inst_data_ok(inst_data_ok0), .inst_rdata(inst_rdata0),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok0), .data_data_ok(data_data_ok0), .data_rdata(data_rdata0),
        .m_req(m_req0), .m_wr(m_wr0), .m_size(m_size0), .m_wstrb(m_wstrb0),
        .m_addr(m_addr0), .m_wdata(m_wdata0),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.FAIR(1'b1)) u1 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok1),
        .inst_data_ok(inst_data_ok1), .inst_rdata(inst_rdata1),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok1), .data_data_ok(data_data_ok1), .data_rdata(data_rdata1),
        .m_req(m_req1), .m_wr(m_wr1), .m_size(m_size1), .m_wstrb(m_wstrb1),
        .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every response pulse pops one expectation; grants never overlap.
    always @(negedge clk) begin
        if (!reset) begin
            if (inst_addr_ok0 || data_addr_ok0)
                check("u0_single_grant", {70'd0, inst_addr_ok0, data_addr_ok0} == 2'b11, 72'd0);
            if (inst_addr_ok1 || data_addr_ok1)
                check("u1_single_grant", {70'd0, inst_addr_ok1, data_addr_ok1} == 2'b11, 72'd0);
            if (inst_data_ok0 || data_data_ok0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {70'd0, inst_data_ok0, data_data_ok0}, 72'd0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("resp_port", {70'd0, inst_data_ok0, data_data_ok0},
                          {70'd0, !e[32], e[32]});
                    if (e[33])
                        check("resp_rdata", {40'd0, e[32] ? data_rdata0 : inst_rdata0},
                              {40'd0, e[31:0]});
                end
            end
        end
    end

    // One full transaction starting from IDLE with requests already driven.
    task automatic run_txn(input bit exp_data, input int addr_wait, input bit combined,
                           input logic [31:0] rd, input bit chk_rd, input bit drop);
        logic [70:0] e_f;
        @(negedge clk);
        check("grant", {70'd0, inst_addr_ok0, data_addr_ok0}, {70'd0, !exp_data, exp_data});
        g1 = {inst_addr_ok1, data_addr_ok1};
        e_f = exp_data ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                       : {1'b0, 2'd2, 4'd0, inst_addr, 32'd0};
        @(posedge clk); #1;
        if (drop) begin
            inst_req = 1'b0;
            data_req = 1'b0;
        end
        for (int i = 0; i < addr_wait; i++) begin
            m_addr_ok = 1'b0;
            @(negedge clk);
            check("m_req_wait", {71'd0, m_req0}, 72'd1);
            check("m_fields_wait", {1'b0, m_wr0, m_size0, m_wstrb0, m_addr0, m_wdata0}, {1'b0, e_f});
            @(posedge clk); #1;
        end
        m_addr_ok = 1'b1;
        m_data_ok = combined;
        m_rdata   = rd;
        if (combined) exp_q.push_back({chk_rd, exp_data, rd});
        @(negedge clk);
        check("m_req", {71'd0, m_req0}, 72'd1);
        check("m_fields", {1'b0, m_wr0, m_size0, m_wstrb0, m_addr0, m_wdata0}, {1'b0, e_f});
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        if (!combined) begin
            m_data_ok = 1'b1;
            m_rdata   = rd;
            exp_q.push_back({chk_rd, exp_data, rd});
            @(negedge clk);
            check("m_req_data", {71'd0, m_req0}, 72'd0);
            @(posedge clk); #1;
            m_data_ok = 1'b0;
        end
        m_rdata = 32'hDEAD_0000;
        @(negedge clk);
        check("resp_pulse", {70'd0, inst_data_ok0, data_data_ok0}, {70'd0, !exp_data, exp_data});
        check("no_grant_in_resp", {70'd0, inst_addr_ok0, data_addr_ok0}, 72'd0);
        @(posedge clk); #1;
        check("queue_drained", 72'(exp_q.size()), 72'd0);
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: outputs stay low even with requests present.
        inst_req = 1'b1; data_req = 1'b1;
        @(negedge clk);
        check("reset_addr_ok", {70'd0, inst_addr_ok0, data_addr_ok0}, 72'd0);
        check("reset_data_ok", {70'd0, inst_data_ok0, data_data_ok0}, 72'd0);
        check("reset_m_port", {m_req0, m_wr0, m_size0, m_wstrb0, m_addr0, m_wdata0}, 72'd0);
        check("reset_rdata", {8'd0, inst_rdata0, data_rdata0}, 72'd0);
        @(posedge clk); #1;
        reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;

        // Reset while a data read waits in DATA: abandoned, no response.
        data_req = 1'b1; data_addr = 32'h8000_0040; data_size = 2'd2;
        @(negedge clk);
        check("rst_txn_grant", {71'd0, data_addr_ok0}, 72'd1);
        @(posedge clk); #1;
        data_req = 1'b0; m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst_in_data_m_req", {71'd0, m_req0}, 72'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("after_rst_m_req", {71'd0, m_req0}, 72'd0);
        check("after_rst_data_ok", {70'd0, inst_data_ok0, data_data_ok0}, 72'd0);
        check("after_rst_m_addr", {40'd0, m_addr0}, 72'd0);
        @(posedge clk); #1;

        // Single fetch after reset, typical latency.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        run_txn(1'b0, 0, 1'b0, 32'h3C08_BFAF, 1'b1, 1'b1);

        // Fixed priority with both ports held: data wins three times.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            data_addr = 32'h0000_1000 + 32'(k * 4);
            run_txn(1'b1, 0, 1'b0, $urandom, 1'b1, 1'b0);
        end
        data_req = 1'b0;
        run_txn(1'b0, 0, 1'b0, 32'h2408_0001, 1'b1, 1'b1);

        // Round-robin instance: after reset, both held -> data, inst, data.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        run_txn(1'b1, 0, 1'b0, 32'h1111_0000, 1'b1, 1'b0);
        check("rr_grant0", {70'd0, g1}, {70'd0, 2'b01});
        run_txn(1'b1, 0, 1'b0, 32'h2222_0000, 1'b1, 1'b0);
        check("rr_grant1", {70'd0, g1}, {70'd0, 2'b10});
        run_txn(1'b1, 0, 1'b0, 32'h3333_0000, 1'b1, 1'b1);
        check("rr_grant2", {70'd0, g1}, {70'd0, 2'b01});

        // Data write: response pulse on the data port only.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h1FAF_0000; data_wdata = 32'h1234_5678;
        run_txn(1'b1, 1, 1'b0, 32'h0, 1'b0, 1'b1);
        data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'd0;

        // Slow slave: five cycles without m_addr_ok, then addr+data together.
        data_req = 1'b1; data_size = 2'(1 + $urandom_range(0, 1));
        data_addr = 32'h0000_2000 | 32'($urandom_range(0, 255) << 2);
        run_txn(1'b1, 5, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1);

        // Best-case fetch: addr_ok and data_ok in the first m_req cycle.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        run_txn(1'b0, 0, 1'b1, 32'h0BAD_BEEF, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        check("final_queue_empty", 72'(exp_q.size()), 72'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
